// File: rtl/screen_sequencer.sv
// Full-screen sequencer: picks the screen to paint, clears the
// draw stage between frames, times each frame and gates the game.
module screen_sequencer #(
  parameter int PIXELS       = 19200,
  parameter int FLASH_PERIOD = 25000000,
  parameter int GO_HOLD      = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic game_over,
  output logic draw_rst,
  output logic showTitle,
  output logic showBlack,
  output logic showGameOver,
  output logic flash,
  output logic plot,
  output logic game_en,
  output logic frame_done
);

  localparam int PW   = $clog2(PIXELS);
  localparam int TMAX = (FLASH_PERIOD > GO_HOLD) ?
                        FLASH_PERIOD : GO_HOLD;
  localparam int TW   = $clog2(TMAX);

  typedef enum logic [2:0] {
    CLR, TITLE, FLASHD, BLACK,
    GAME, GO, TWAIT, GWAIT
  } state_t;

  state_t state, nstate;
  state_t target, ntarget;
  logic lastf, nlastf;
  logic [PW-1:0] pix;
  logic [TW-1:0] timer;
  logic start_q;

  logic sedge, draw, waiting;
  logic pend, tflash, thold;

  assign sedge   = start & ~start_q;
  assign draw    = (state == TITLE) || (state == FLASHD) ||
                   (state == BLACK) || (state == GO);
  assign waiting = (state == TWAIT) || (state == GWAIT);
  assign pend    = (pix == PW'(PIXELS - 1));
  assign tflash  = (timer == TW'(FLASH_PERIOD - 1));
  assign thold   = (timer == TW'(GO_HOLD - 1));

  always_comb begin
    nstate  = state;
    ntarget = target;
    nlastf  = lastf;
    unique case (state)
      CLR: nstate = target;
      TITLE: begin
        nlastf = 1'b0;
        if (pend) nstate = TWAIT;
      end
      FLASHD: begin
        nlastf = 1'b1;
        if (pend) nstate = TWAIT;
      end
      BLACK: if (pend) nstate = GAME;
      GO:    if (pend) nstate = GWAIT;
      TWAIT: begin
        // a start request beats the flash timer
        if (sedge) begin
          ntarget = BLACK;
          nstate  = CLR;
        end else if (tflash) begin
          ntarget = lastf ? TITLE : FLASHD;
          nstate  = CLR;
        end
      end
      GAME: begin
        if (game_over) begin
          ntarget = GO;
          nstate  = CLR;
        end
      end
      GWAIT: begin
        if (sedge || thold) begin
          ntarget = TITLE;
          nstate  = CLR;
        end
      end
      default: nstate = CLR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLR;
      target  <= TITLE;
      lastf   <= 1'b0;
      pix     <= '0;
      timer   <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= nstate;
      target  <= ntarget;
      lastf   <= nlastf;
      start_q <= start;
      if (draw && nstate == state)
        pix <= pix + 1'b1;
      else
        pix <= '0;
      if (waiting && nstate == state)
        timer <= timer + 1'b1;
      else
        timer <= '0;
    end
  end

  always_comb begin
    draw_rst     = 1'b1;
    showTitle    = 1'b0;
    showBlack    = 1'b0;
    showGameOver = 1'b0;
    flash        = 1'b0;
    plot         = 1'b0;
    game_en      = 1'b0;
    frame_done   = draw & pend;
    unique case (state)
      CLR:    draw_rst = 1'b0;
      TITLE: begin
        showTitle = 1'b1;
        plot      = 1'b1;
      end
      FLASHD: begin
        flash = 1'b1;
        plot  = 1'b1;
      end
      // title keeps the address moving; black wins on colour
      BLACK: begin
        showBlack = 1'b1;
        showTitle = 1'b1;
        plot      = 1'b1;
      end
      GAME:   game_en = 1'b1;
      GO: begin
        showGameOver = 1'b1;
        plot         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with small frame/timer bounds.
module tb_screen_sequencer;

  localparam int PIX = 16;
  localparam int FP  = 40;
  localparam int GH  = 60;

  logic clk = 1'b0;
  logic rst, start, game_over;
  logic draw_rst, showTitle, showBlack, showGameOver;
  logic flash, plot, game_en, frame_done;
  logic [7:0] outs;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [7:0] CLRV   = 8'h00;
  localparam logic [7:0] IDLEV  = 8'h80;
  localparam logic [7:0] TITLEV = 8'hC4;
  localparam logic [7:0] FLASHV = 8'h8C;
  localparam logic [7:0] BLACKV = 8'hE4;
  localparam logic [7:0] GOV    = 8'h94;
  localparam logic [7:0] GAMEV  = 8'h82;

  screen_sequencer #(
    .PIXELS(PIX),
    .FLASH_PERIOD(FP),
    .GO_HOLD(GH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .game_over(game_over),
    .draw_rst(draw_rst),
    .showTitle(showTitle),
    .showBlack(showBlack),
    .showGameOver(showGameOver),
    .flash(flash),
    .plot(plot),
    .game_en(game_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign outs = {draw_rst, showTitle, showBlack,
                 showGameOver, flash, plot,
                 game_en, frame_done};

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag,
                     input logic [7:0] exp);
    @(negedge clk);
    check(tag, outs, exp);
  endtask

  task automatic idle(input string tag,
                      input logic [7:0] exp,
                      input int n);
    for (int i = 0; i < n; i++) cyc(tag, exp);
  endtask

  task automatic frame(input string tag,
                       input logic [7:0] pat,
                       input int n);
    for (int i = 0; i < n; i++)
      cyc(tag, pat | ((i == PIX - 1) ? 8'h01 : 8'h00));
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    game_over = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hold", outs, CLRV);
    rst = 1'b1;
    #1 check("rel_clr", outs, CLRV);
    frame("title0", TITLEV, PIX);
    idle("twait0", IDLEV, FP);
    cyc("clr_flash", CLRV);
    frame("flash0", FLASHV, PIX);
    idle("twait1", IDLEV, FP);
    cyc("clr_title", CLRV);

    for (int i = 0; i < PIX; i++) begin
      cyc("title1", TITLEV | ((i == PIX - 1) ? 8'h01 : 8'h00));
      if (i == 7) start = 1'b1;
    end
    idle("held_start", IDLEV, FP);
    cyc("held_clr", CLRV);
    frame("flash1", FLASHV, PIX);
    idle("twait2", IDLEV, 3);
    start = 1'b0;
    cyc("twait3", IDLEV);
    start = 1'b1;
    cyc("start_clr", CLRV);
    frame("black0", BLACKV, PIX);
    idle("game0", GAMEV, 4);
    start = 1'b0;
    idle("game1", GAMEV, 4);
    game_over = 1'b1;
    cyc("go_clr", CLRV);
    game_over = 1'b0;
    frame("go0", GOV, PIX);
    idle("gwait0", IDLEV, GH);
    cyc("gw_clr", CLRV);
    frame("title2", TITLEV, PIX);

    idle("twait4", IDLEV, 2);
    game_over = 1'b1;
    cyc("go_ignored", IDLEV);
    game_over = 1'b0;
    idle("twait5", IDLEV, 2);
    start = 1'b1;
    cyc("start_clr2", CLRV);
    frame("black1", BLACKV, PIX);
    idle("game2", GAMEV, 3);
    start = 1'b0;
    cyc("game3", GAMEV);
    game_over = 1'b1;
    cyc("go_clr2", CLRV);
    game_over = 1'b0;
    frame("go1", GOV, PIX);
    idle("gwait1", IDLEV, 10);
    start = 1'b1;
    cyc("gw_start_clr", CLRV);
    frame("title3", TITLEV, PIX);
    start = 1'b0;

    idle("twait6", IDLEV, 2);
    start = 1'b1;
    cyc("start_clr3", CLRV);
    start = 1'b0;
    frame("black2", BLACKV, 8);
    rst = 1'b0;
    #1 check("async_rst", outs, CLRV);
    idle("rst_low", CLRV, 2);
    rst = 1'b1;
    #1 check("rel_clr2", outs, CLRV);
    frame("title4", TITLEV, PIX);
    cyc("twait7", IDLEV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
